bit_serial_approx_subtractor: RTL

BIT_SERIAL_APPROX_SUBTRACTOR -- requirements
Module: bit_serial_approx_subtractor

---
 rtl/bit_serial_approx_subtractor.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bit_serial_approx_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : bit_serial_approx_subtractor
//  Function : LSB-first bit-serial subtractor (diff = a - b). It accepts one
//             operand pair per transaction and returns one result. The lowest
//             APPROX_BITS bits can run in borrow-masked (approximate) mode,
//             which is selected per transaction by mask_en.
//  Revision : 1.0  initial release
// ============================================================================
module bit_serial_approx_subtractor #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mask_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // The counter must be able to hold WIDTH itself, so the approx-limit compare
  // stays valid when APPROX_BITS == WIDTH.
  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  C_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  C_APPROX = CNT_W'(APPROX_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_mask;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_approx;
  logic             w_masked;
  logic             w_axb;
  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_diff_shift;

  // With APPROX_BITS == 0, no bit position can ever be masked.
  generate
    if (APPROX_BITS == 0) begin : g_no_approx
      assign w_in_approx = 1'b0;
    end else begin : g_approx
      assign w_in_approx = (r_cnt < C_APPROX);
    end
  endgenerate

  // The current bit is always bit 0 of the operand shift registers.
  assign w_masked  = r_mask & w_in_approx;
  assign w_axb     = r_a[0] ^ r_b[0];
  assign w_d       = w_masked ? w_axb : (w_axb ^ r_br);
  assign w_br_next = w_masked ? 1'b0
                              : ((~r_a[0] & r_b[0]) | (~w_axb & r_br));

  // Result bits enter at the MSB end. After WIDTH shifts, bit 0 has reached position 0.
  generate
    if (WIDTH == 1) begin : g_diff_single
      assign w_diff_shift = w_d;
    end else begin : g_diff_multi
      assign w_diff_shift = {w_d, r_diff[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == C_LAST) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: load the operands on accept, then compute one bit per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_diff <= '0;
      r_mask <= 1'b0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a    <= a;
            r_b    <= b;
            r_mask <= mask_en;
            r_br   <= 1'b0;
            r_cnt  <= '0;
          end
        end
        ST_SHIFT: begin
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_diff <= w_diff_shift;
          r_br   <= w_br_next;
          r_cnt  <= r_cnt + 1'b1;
        end
        default: begin
          // DONE holds the result registers until the consumer takes it.
        end
      endcase
    end
  end

  // After the final shift, the running borrow equals the borrow out of the MSB.
  assign diff       = r_diff;
  assign borrow_out = r_br;

endmodule
`default_nettype wire
